gb_irq_ctrl: RTL

GB_IRQ_CTRL -- requirements
Module: gb_irq_ctrl

---
 rtl/gb_irq_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/gb_irq_ctrl.sv
// Game Boy style interrupt controller: IF/IE registers, rising-edge capture and lowest-index priority vector.
// Define IRQ_SYNC_EN to pass irq_i through a two-flop synchronizer (adds 2 cycles of set latency).
module gb_irq_ctrl #(
    parameter int          NUM_IRQ = 5,
    parameter logic [15:0] IF_ADDR = 16'hFF0F,
    parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        addr,
    input  logic [7:0]         data_i,
    input  logic               wren,
    output logic [7:0]         data_o,
    output logic               sel_o,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               clear_interrupt_flag,
    output logic [7:0]         reg_IF,
    output logic [7:0]         reg_IE,
    output logic               irq_pending,
    output logic [15:0]        irq_vector
);

    logic [NUM_IRQ-1:0] r_if;
    logic [NUM_IRQ-1:0] r_prev;
    logic [7:0]         r_ie;

    logic [NUM_IRQ-1:0] w_src;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_active;
    logic [NUM_IRQ-1:0] w_if_wr;
    logic [NUM_IRQ-1:0] w_wr_active;
    logic [NUM_IRQ-1:0] w_clr_mask;
    logic [NUM_IRQ-1:0] w_if_next;
    logic [7:0]         w_if_full;
    logic [2:0]         w_idx;
    logic               w_if_sel;
    logic               w_ie_sel;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = irq_i;
`endif

    assign w_if_sel = (addr == IF_ADDR);
    assign w_ie_sel = (addr == IE_ADDR);
    assign sel_o    = w_if_sel | w_ie_sel;

    assign w_rise   = w_src & ~r_prev;
    assign w_active = r_if & r_ie[NUM_IRQ-1:0];

    // CPU write lands first, the acknowledge then clears the lowest enabled bit of the written value.
    always_comb begin
        w_if_wr = r_if;
        if (wren && w_if_sel) begin
            w_if_wr = data_i[NUM_IRQ-1:0];
        end
    end

    assign w_wr_active = w_if_wr & r_ie[NUM_IRQ-1:0];
    assign w_clr_mask  = clear_interrupt_flag ? (w_wr_active & (~w_wr_active + NUM_IRQ'(1))) : '0;
    assign w_if_next   = (w_if_wr & ~w_clr_mask) | w_rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if   <= '0;
            r_prev <= '0;
            r_ie   <= 8'h00;
        end else begin
            r_if   <= w_if_next;
            r_prev <= w_src;
            if (wren && w_ie_sel) begin
                r_ie <= data_i;
            end
        end
    end

    // Scanning downward leaves the lowest set index as the winner.
    always_comb begin
        w_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    assign irq_pending = |w_active;
    assign irq_vector  = irq_pending ? (16'h0040 + {10'd0, w_idx, 3'd0}) : 16'h0000;

    always_comb begin
        w_if_full = 8'hFF;
        w_if_full[NUM_IRQ-1:0] = r_if;
    end

    assign reg_IF = w_if_full;
    assign reg_IE = r_ie;

    always_comb begin
        data_o = 8'h00;
        if (w_if_sel) begin
            data_o = w_if_full;
        end else if (w_ie_sel) begin
            data_o = r_ie;
        end
    end

endmodule
